// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush-driven bubbles
// and a saturating bubble counter for debug.
module id_ex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        ConMux_i,
    input  logic [DATA_W-1:0] RSdata_i,
    input  logic [DATA_W-1:0] RTdata_i,
    input  logic [DATA_W-1:0] Imm_i,
    input  logic [4:0]        RSaddr_i,
    input  logic [4:0]        RTaddr_i,
    input  logic [4:0]        RDaddr_i,
    input  logic              Flush_i,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              ALUSrc_o,
    output logic [1:0]        ALUOp_o,
    output logic              RegDst_o,
    output logic [DATA_W-1:0] RSdata_o,
    output logic [DATA_W-1:0] RTdata_o,
    output logic [DATA_W-1:0] Imm_o,
    output logic [4:0]        RSaddr_o,
    output logic [4:0]        RTaddr_o,
    output logic [4:0]        RDaddr_o,
    output logic              PCWrite_o,
    output logic              IFIDWrite_o,
    output logic [CNT_W-1:0]  BubbleCnt_o
);

    logic [7:0]        r_ctrl;
    logic [DATA_W-1:0] r_rsdata;
    logic [DATA_W-1:0] r_rtdata;
    logic [DATA_W-1:0] r_imm;
    logic [4:0]        r_rsaddr;
    logic [4:0]        r_rtaddr;
    logic [4:0]        r_rdaddr;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic w_hazard;
    logic w_stall;
    logic w_bubble;

    // Both ID source fields are compared regardless of opcode; $0 never stalls.
    always_comb begin
        w_hazard = r_ctrl[5] && (r_rtaddr != 5'd0) &&
                   ((r_rtaddr == RSaddr_i) || (r_rtaddr == RTaddr_i));
        w_stall  = w_hazard && !Flush_i;
        w_bubble = w_hazard || Flush_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ctrl       <= '0;
            r_rsdata     <= '0;
            r_rtdata     <= '0;
            r_imm        <= '0;
            r_rsaddr     <= '0;
            r_rtaddr     <= '0;
            r_rdaddr     <= '0;
            r_bubble_cnt <= '0;
        end else if (w_bubble) begin
            r_ctrl       <= '0;
            r_rsdata     <= '0;
            r_rtdata     <= '0;
            r_imm        <= '0;
            r_rsaddr     <= '0;
            r_rtaddr     <= '0;
            r_rdaddr     <= '0;
            if (r_bubble_cnt != '1) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end else begin
            r_ctrl       <= ConMux_i;
            r_rsdata     <= RSdata_i;
            r_rtdata     <= RTdata_i;
            r_imm        <= Imm_i;
            r_rsaddr     <= RSaddr_i;
            r_rtaddr     <= RTaddr_i;
            r_rdaddr     <= RDaddr_i;
        end
    end

    assign RegWrite_o  = r_ctrl[7];
    assign MemtoReg_o  = r_ctrl[6];
    assign MemRead_o   = r_ctrl[5];
    assign MemWrite_o  = r_ctrl[4];
    assign ALUSrc_o    = r_ctrl[3];
    assign ALUOp_o     = r_ctrl[2:1];
    assign RegDst_o    = r_ctrl[0];
    assign RSdata_o    = r_rsdata;
    assign RTdata_o    = r_rtdata;
    assign Imm_o       = r_imm;
    assign RSaddr_o    = r_rsaddr;
    assign RTaddr_o    = r_rtaddr;
    assign RDaddr_o    = r_rdaddr;
    assign PCWrite_o   = !w_stall;
    assign IFIDWrite_o = !w_stall;
    assign BubbleCnt_o = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push expected results,
// a monitor pops and compares once per cycle. A CNT_W=2 copy checks saturation.
module tb_id_ex_stage;

    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              rst;
    logic [7:0]        con;
    logic [DATA_W-1:0] rsd, rtd, imm;
    logic [4:0]        rsa, rta, rda;
    logic              flush;

    logic              regwrite, memtoreg, memread, memwrite, alusrc, regdst;
    logic [1:0]        aluop;
    logic [DATA_W-1:0] rsd_o, rtd_o, imm_o;
    logic [4:0]        rsa_o, rta_o, rda_o;
    logic              pcw, ifidw;
    logic [15:0]       cnt;

    logic              s_regwrite, s_memtoreg, s_memread, s_memwrite, s_alusrc, s_regdst;
    logic [1:0]        s_aluop;
    logic [DATA_W-1:0] s_rsd_o, s_rtd_o, s_imm_o;
    logic [4:0]        s_rsa_o, s_rta_o, s_rda_o;
    logic              s_pcw, s_ifidw;
    logic [1:0]        s_cnt;

    id_ex_stage #(.DATA_W(DATA_W), .CNT_W(16)) u_dut (
        .clk_i(clk), .rst_i(rst), .ConMux_i(con),
        .RSdata_i(rsd), .RTdata_i(rtd), .Imm_i(imm),
        .RSaddr_i(rsa), .RTaddr_i(rta), .RDaddr_i(rda), .Flush_i(flush),
        .RegWrite_o(regwrite), .MemtoReg_o(memtoreg), .MemRead_o(memread),
        .MemWrite_o(memwrite), .ALUSrc_o(alusrc), .ALUOp_o(aluop), .RegDst_o(regdst),
        .RSdata_o(rsd_o), .RTdata_o(rtd_o), .Imm_o(imm_o),
        .RSaddr_o(rsa_o), .RTaddr_o(rta_o), .RDaddr_o(rda_o),
        .PCWrite_o(pcw), .IFIDWrite_o(ifidw), .BubbleCnt_o(cnt)
    );

    id_ex_stage #(.DATA_W(DATA_W), .CNT_W(2)) u_sat (
        .clk_i(clk), .rst_i(rst), .ConMux_i(con),
        .RSdata_i(rsd), .RTdata_i(rtd), .Imm_i(imm),
        .RSaddr_i(rsa), .RTaddr_i(rta), .RDaddr_i(rda), .Flush_i(flush),
        .RegWrite_o(s_regwrite), .MemtoReg_o(s_memtoreg), .MemRead_o(s_memread),
        .MemWrite_o(s_memwrite), .ALUSrc_o(s_alusrc), .ALUOp_o(s_aluop), .RegDst_o(s_regdst),
        .RSdata_o(s_rsd_o), .RTdata_o(s_rtd_o), .Imm_o(s_imm_o),
        .RSaddr_o(s_rsa_o), .RTaddr_o(s_rta_o), .RDaddr_o(s_rda_o),
        .PCWrite_o(s_pcw), .IFIDWrite_o(s_ifidw), .BubbleCnt_o(s_cnt)
    );

    typedef struct {
        logic        pcw;
        logic [7:0]  ctrl;
        logic [95:0] data;
        logic [14:0] addr;
        logic [15:0] cnt;
        logic [1:0]  satcnt;
    } exp_t;

    exp_t q_exp[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   outstanding = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: drive inputs after the falling edge, push the hand-given
    // expectation (comb PCWrite now, register contents after the next edge).
    task automatic cyc(input logic r, input logic f, input logic [7:0] c,
                       input logic [4:0] a_rs, input logic [4:0] a_rt, input logic [4:0] a_rd,
                       input logic [31:0] d_rs, input logic [31:0] d_rt, input logic [31:0] d_im,
                       input logic e_pcw, input logic e_zero, input int e_cnt);
        exp_t e;
        @(negedge clk);
        rst = r; flush = f; con = c;
        rsa = a_rs; rta = a_rt; rda = a_rd;
        rsd = d_rs; rtd = d_rt; imm = d_im;
        e.pcw    = e_pcw;
        e.ctrl   = e_zero ? 8'd0  : c;
        e.data   = e_zero ? 96'd0 : {d_rs, d_rt, d_im};
        e.addr   = e_zero ? 15'd0 : {a_rs, a_rt, a_rd};
        e.cnt    = 16'(e_cnt);
        e.satcnt = (e_cnt > 3) ? 2'd3 : 2'(e_cnt);
        q_exp.push_back(e);
        outstanding++;
    endtask

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q_exp.size() != 0) begin
                e = q_exp.pop_front();
                chk("PCWrite", 96'(pcw), 96'(e.pcw));
                chk("IFIDWrite", 96'(ifidw), 96'(e.pcw));
                @(posedge clk);
                #1;
                chk("ctrl", 96'({regwrite, memtoreg, memread, memwrite, alusrc, aluop, regdst}), 96'(e.ctrl));
                chk("data", {rsd_o, rtd_o, imm_o}, e.data);
                chk("addr", 96'({rsa_o, rta_o, rda_o}), 96'(e.addr));
                chk("BubbleCnt", 96'(cnt), 96'(e.cnt));
                chk("BubbleCnt_sat", 96'(s_cnt), 96'(e.satcnt));
                outstanding--;
            end
        end
    end

    localparam logic [7:0] RTYPE = 8'b1000_0011;
    localparam logic [7:0] LW    = 8'b1110_1000;

    initial begin : stim
        int budget;
        rst = 1'b1; flush = 1'b1; con = 8'hFF;
        rsa = 5'd31; rta = 5'd31; rda = 5'd31;
        rsd = 32'hDEAD_BEEF; rtd = 32'hCAFE_F00D; imm = 32'h1234_5678;
        //    rst  fl  ctrl   rs     rt     rd     rsdata        rtdata        imm           pcw  zero cnt
        cyc(1'b1, 1'b1, 8'hFF, 5'd31, 5'd31, 5'd31, 32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 1'b1, 1'b1, 0);
        cyc(1'b1, 1'b0, LW,    5'd9,  5'd9,  5'd9,  32'h11111111, 32'h22222222, 32'h33333333, 1'b1, 1'b1, 0);
        // pass-through
        cyc(1'b0, 1'b0, RTYPE, 5'd1,  5'd2,  5'd8,  32'h00001234, 32'hAAAA5555, 32'hFFFFFFF0, 1'b1, 1'b0, 0);
        // load-use: stall once, then re-present
        cyc(1'b0, 1'b0, LW,    5'd3,  5'd9,  5'd0,  32'h00000100, 32'h00000200, 32'h00000004, 1'b1, 1'b0, 0);
        cyc(1'b0, 1'b0, RTYPE, 5'd9,  5'd4,  5'd12, 32'h00000005, 32'h00000006, 32'h00000000, 1'b0, 1'b1, 1);
        cyc(1'b0, 1'b0, RTYPE, 5'd9,  5'd4,  5'd12, 32'h00000005, 32'h00000006, 32'h00000000, 1'b1, 1'b0, 1);
        // $0 producer never stalls
        cyc(1'b0, 1'b0, LW,    5'd1,  5'd0,  5'd0,  32'h00000010, 32'h00000020, 32'h00000008, 1'b1, 1'b0, 1);
        cyc(1'b0, 1'b0, RTYPE, 5'd0,  5'd5,  5'd6,  32'h00000030, 32'h00000040, 32'h00000000, 1'b1, 1'b0, 1);
        // no register match
        cyc(1'b0, 1'b0, LW,    5'd2,  5'd9,  5'd0,  32'h00000050, 32'h00000060, 32'h0000000C, 1'b1, 1'b0, 1);
        cyc(1'b0, 1'b0, RTYPE, 5'd10, 5'd11, 5'd13, 32'h00000070, 32'h00000080, 32'h00000000, 1'b1, 1'b0, 1);
        // flush together with hazard: no stall, one bubble
        cyc(1'b0, 1'b0, LW,    5'd2,  5'd9,  5'd0,  32'h00000090, 32'h000000A0, 32'h00000010, 1'b1, 1'b0, 1);
        cyc(1'b0, 1'b1, RTYPE, 5'd9,  5'd4,  5'd14, 32'h000000B0, 32'h000000C0, 32'h00000000, 1'b1, 1'b1, 2);
        // back-to-back lw with matching rt: one stall per dependent pair
        cyc(1'b0, 1'b0, LW,    5'd1,  5'd7,  5'd0,  32'h00000111, 32'h00000222, 32'h00000014, 1'b1, 1'b0, 2);
        cyc(1'b0, 1'b0, LW,    5'd2,  5'd7,  5'd0,  32'h00000333, 32'h00000444, 32'h00000018, 1'b0, 1'b1, 3);
        cyc(1'b0, 1'b0, LW,    5'd2,  5'd7,  5'd0,  32'h00000333, 32'h00000444, 32'h00000018, 1'b1, 1'b0, 3);
        cyc(1'b0, 1'b0, RTYPE, 5'd7,  5'd3,  5'd15, 32'h00000555, 32'h00000666, 32'h00000000, 1'b0, 1'b1, 4);
        cyc(1'b0, 1'b0, RTYPE, 5'd7,  5'd3,  5'd15, 32'h00000555, 32'h00000666, 32'h00000000, 1'b1, 1'b0, 4);
        // reset asserted mid-stall
        cyc(1'b0, 1'b0, LW,    5'd1,  5'd6,  5'd0,  32'h00000777, 32'h00000888, 32'h0000001C, 1'b1, 1'b0, 4);
        cyc(1'b1, 1'b0, RTYPE, 5'd6,  5'd2,  5'd16, 32'h00000999, 32'h00000AAA, 32'h00000000, 1'b0, 1'b1, 0);
        cyc(1'b0, 1'b0, RTYPE, 5'd6,  5'd2,  5'd16, 32'h00000999, 32'h00000AAA, 32'h00000000, 1'b1, 1'b0, 0);
        // five flushes: 16-bit counter climbs, 2-bit counter saturates at 3
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b0, 1'b1, RTYPE, 5'd1, 5'd2, 5'd3, 32'h00000001, 32'h00000002, 32'h00000003, 1'b1, 1'b1, i);
        end
        @(negedge clk);
        flush = 1'b0;
        budget = 0;
        while (outstanding != 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (outstanding != 0) begin
            n_total++;
            $display("FAIL drain: %0d records outstanding, required 0", outstanding);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
